// File: rtl/background_pkg.sv
// background_pkg: shared colours, bordersDR encodings and flash FSM states for the background layer.
package background_pkg;
  localparam logic [7:0] DEF_BORDER_COLOR      = 8'h80;
  localparam logic [7:0] DEF_PLAYER_ZONE_COLOR = 8'h10;
  localparam logic [7:0] DEF_FLASH_COLOR       = 8'hFF;
  localparam logic [7:0] DEF_STAR_COLOR        = 8'h49;
  localparam logic [7:0] DEF_BACKGROUND_COLOR  = 8'h00;
  localparam logic [1:0] DR_NONE        = 2'b00;
  localparam logic [1:0] DR_BORDER      = 2'b01;
  localparam logic [1:0] DR_PLAYER_ZONE = 2'b10;
  typedef enum logic {IDLE, FLASH} flash_state_e;
endpackage

// File: rtl/background_scroller_if.sv
// background_scroller_if: pixel coordinates in, colour and collision code out.
interface background_scroller_if #(parameter int PW = 11, parameter int RW = 8);
  logic [PW-1:0] pixelX;
  logic [PW-1:0] pixelY;
  logic          startOfFrame;
  logic [RW-1:0] background_RGB;
  logic [1:0]    bordersDR;
  modport master (output pixelX, pixelY, startOfFrame, input background_RGB, bordersDR);
  modport slave  (input pixelX, pixelY, startOfFrame, output background_RGB, bordersDR);
endinterface

// File: rtl/star_field.sv
// star_field: frame-divided vertical scroll offset and a combinational star-pixel test for the current pixel.
module star_field #(
  parameter int PW         = 11,
  parameter int Y_FRAME    = 479,
  parameter int L          = 5,
  parameter int SCROLL_DIV = 2
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          startOfFrame,
  input  logic [PW-1:0] pixelX,
  input  logic [PW-1:0] pixelY,
  output logic          star_hit
);
  localparam int DW = SCROLL_DIV > 1 ? $clog2(SCROLL_DIV) : 1;
  localparam logic [PW-1:0] M = PW'((1 << L) - 1);
  logic [DW-1:0] div_q, div_d;
  logic [PW-1:0] scroll_q, scroll_d;
  logic [PW-1:0] sy, cx, cy;
  logic wrap;
  always_comb begin
    wrap = div_q == DW'(SCROLL_DIV - 1);
    div_d = !startOfFrame ? div_q : wrap ? '0 : div_q + 1'b1;
    scroll_d = !(startOfFrame && wrap) ? scroll_q : scroll_q == PW'(Y_FRAME) ? '0 : scroll_q + 1'b1;
    // Subtracting the offset makes the pattern slide downward as the offset grows.
    sy = pixelY - scroll_q + (pixelY < scroll_q ? PW'(Y_FRAME + 1) : '0);
    cx = pixelX >> L;
    cy = sy >> L;
    star_hit = (pixelX & M) == ((cx * PW'(5) + cy * PW'(3)) & M) &&
               (sy & M) == ((cx * PW'(3) + cy * PW'(7)) & M);
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_q    <= '0;
      scroll_q <= '0;
    end else begin
      div_q    <= div_d;
      scroll_q <= scroll_d;
    end
  end
endmodule

// File: rtl/background_scroller.sv
// background_scroller: lowest-priority VGA layer drawing borders, player-zone line, scrolling stars and border flash.
module background_scroller
  import background_pkg::*;
#(
  parameter int RGB_WIDTH      = 8,
  parameter int PIXEL_WIDTH    = 11,
  parameter int X_FRAME        = 639,
  parameter int Y_FRAME        = 479,
  parameter int SIDE_OFFSET    = 20,
  parameter int TOP_Y          = 20,
  parameter int BOTTOM_OFFSET  = 20,
  parameter int PLAYER_ZONE_Y  = 310,
  parameter int STAR_CELL_LOG2 = 5,
  parameter int SCROLL_DIV     = 2,
  parameter int FLASH_FRAMES   = 32,
  parameter int FLASH_HALF     = 4,
  parameter logic [RGB_WIDTH-1:0] BORDER_COLOR      = RGB_WIDTH'(DEF_BORDER_COLOR),
  parameter logic [RGB_WIDTH-1:0] PLAYER_ZONE_COLOR = RGB_WIDTH'(DEF_PLAYER_ZONE_COLOR),
  parameter logic [RGB_WIDTH-1:0] FLASH_COLOR       = RGB_WIDTH'(DEF_FLASH_COLOR),
  parameter logic [RGB_WIDTH-1:0] STAR_COLOR        = RGB_WIDTH'(DEF_STAR_COLOR),
  parameter logic [RGB_WIDTH-1:0] BACKGROUND_COLOR  = RGB_WIDTH'(DEF_BACKGROUND_COLOR)
) (
  input  logic                  clk,
  input  logic                  resetN,
  background_scroller_if.slave  pix,
  input  logic                  stars_en,
  input  logic                  flash_req,
  output logic                  flashing
);
  localparam int PW = PIXEL_WIDTH;
  localparam int FW = FLASH_FRAMES > 1 ? $clog2(FLASH_FRAMES) : 1;
  localparam int HW = FLASH_HALF > 1 ? $clog2(FLASH_HALF) : 1;
  localparam logic [PW-1:0] XL = PW'(SIDE_OFFSET);
  localparam logic [PW-1:0] XR = PW'(X_FRAME - SIDE_OFFSET);
  localparam logic [PW-1:0] YT = PW'(TOP_Y);
  localparam logic [PW-1:0] YB = PW'(Y_FRAME - BOTTOM_OFFSET);
  localparam logic [PW-1:0] YP = PW'(PLAYER_ZONE_Y);
  flash_state_e state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [HW-1:0] phase_cnt_q, phase_cnt_d;
  logic phase_on_q, phase_on_d, flashing_q, flashing_d;
  logic [RGB_WIDTH-1:0] rgb_q, rgb_d;
  logic [1:0] dr_q, dr_d;
  logic star_hit, on_screen, border, pz, interior, star, count, last, half_end;
  star_field #(
    .PW(PW), .Y_FRAME(Y_FRAME), .L(STAR_CELL_LOG2), .SCROLL_DIV(SCROLL_DIV)
  ) u_star (
    .clk(clk), .resetN(resetN), .startOfFrame(pix.startOfFrame),
    .pixelX(pix.pixelX), .pixelY(pix.pixelY), .star_hit(star_hit)
  );
  always_comb begin
    on_screen = pix.pixelX <= PW'(X_FRAME) && pix.pixelY <= PW'(Y_FRAME);
    border = pix.pixelX == XL || pix.pixelX == XR || pix.pixelY == YT || pix.pixelY == YB;
    pz = pix.pixelY == YP;
    interior = pix.pixelX > XL && pix.pixelX < XR && pix.pixelY > YT && pix.pixelY < YB && !pz;
    star = stars_en && interior && star_hit;
    dr_d = !on_screen ? DR_NONE : pz ? DR_PLAYER_ZONE : border ? DR_BORDER : DR_NONE;
    rgb_d = !on_screen ? BACKGROUND_COLOR : pz ? PLAYER_ZONE_COLOR :
            border ? (state_q == FLASH && phase_on_q ? FLASH_COLOR : BORDER_COLOR) :
            star ? STAR_COLOR : BACKGROUND_COLOR;
    count = state_q == FLASH && pix.startOfFrame;
    last = frame_q == FW'(FLASH_FRAMES - 1);
    half_end = phase_cnt_q == HW'(FLASH_HALF - 1);
    // A request always wins over a same-cycle frame pulse and restarts the flash.
    state_d = flash_req ? FLASH : count && last ? IDLE : state_q;
    frame_d = flash_req ? '0 : count ? frame_q + 1'b1 : frame_q;
    phase_cnt_d = flash_req ? '0 : count ? (half_end ? '0 : phase_cnt_q + 1'b1) : phase_cnt_q;
    phase_on_d = flash_req ? 1'b1 : count && half_end ? !phase_on_q : phase_on_q;
    flashing_d = state_d == FLASH;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      phase_cnt_q <= '0;
      phase_on_q  <= 1'b0;
      flashing_q  <= 1'b0;
      rgb_q       <= BACKGROUND_COLOR;
      dr_q        <= DR_NONE;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      phase_cnt_q <= phase_cnt_d;
      phase_on_q  <= phase_on_d;
      flashing_q  <= flashing_d;
      rgb_q       <= rgb_d;
      dr_q        <= dr_d;
    end
  end
  assign pix.background_RGB = rgb_q;
  assign pix.bordersDR = dr_q;
  assign flashing = flashing_q;
endmodule

// File: tb/tb_background_scroller.sv
// tb_background_scroller: directed and random pixels checked against a frame-level reference model.
module tb_background_scroller;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic stars_en = 1'b0;
  logic flash_req = 1'b0;
  logic flashing;
  int checks = 0;
  int errors = 0;
  int m_sof = 0;
  bit m_fl = 0;
  int m_fr = 0;
  int xs[8] = '{19, 20, 21, 618, 619, 620, 639, 640};
  int ys[9] = '{19, 20, 21, 309, 310, 311, 459, 479, 480};
  always #5 clk = ~clk;
  background_scroller_if #(.PW(11), .RW(8)) pix ();
  background_scroller dut (
    .clk(clk), .resetN(resetN), .pix(pix), .stars_en(stars_en),
    .flash_req(flash_req), .flashing(flashing)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int scroll();
    return (m_sof / 2) % 480;
  endfunction
  function automatic bit is_star(int x, int y);
    int sy, cx, cy;
    if (!(x > 20 && x < 619 && y > 20 && y < 459 && y != 310)) return 0;
    sy = (y - scroll() + 480) % 480;
    cx = x / 32;
    cy = sy / 32;
    return x % 32 == (cx * 5 + cy * 3) % 32 && sy % 32 == (cx * 3 + cy * 7) % 32;
  endfunction
  function automatic logic [9:0] expect_px(int x, int y, bit se);
    if (x > 639 || y > 479) return {8'h00, 2'b00};
    if (y == 310) return {8'h10, 2'b10};
    if (x == 20 || x == 619 || y == 20 || y == 459)
      return {(m_fl && (m_fr / 4) % 2 == 0) ? 8'hFF : 8'h80, 2'b01};
    if (se && is_star(x, y)) return {8'h49, 2'b00};
    return {8'h00, 2'b00};
  endfunction
  task automatic cyc(input int x, input int y, input bit sof, input bit fr, input bit se);
    logic [9:0] e;
    pix.pixelX = 11'(x);
    pix.pixelY = 11'(y);
    pix.startOfFrame = sof;
    flash_req = fr;
    stars_en = se;
    e = expect_px(x, y, se);
    @(posedge clk);
    #1;
    if (fr) begin
      m_fl = 1;
      m_fr = 0;
    end else if (sof && m_fl) begin
      if (m_fr == 31) m_fl = 0;
      else m_fr++;
    end
    if (sof) m_sof++;
    check("rgb", 32'(pix.background_RGB), 32'(e[9:2]));
    check("dr", 32'(pix.bordersDR), 32'(e[1:0]));
    check("flashing", 32'(flashing), 32'(m_fl));
  endtask
  task automatic star_xy(input int cx, input int cy, output int x, output int y);
    x = cx * 32 + (cx * 5 + cy * 3) % 32;
    y = (cy * 32 + (cx * 3 + cy * 7) % 32 + scroll()) % 480;
  endtask
  initial begin
    int x, y;
    pix.pixelX = '0;
    pix.pixelY = '0;
    pix.startOfFrame = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rgb", 32'(pix.background_RGB), 32'h00);
    check("reset_dr", 32'(pix.bordersDR), 32'h0);
    check("reset_flashing", 32'(flashing), 32'h0);
    resetN = 1'b1;
    cyc(20, 100, 0, 0, 0);
    cyc(100, 310, 0, 0, 0);
    cyc(100, 20, 0, 0, 0);
    cyc(20, 310, 0, 0, 0);
    cyc(700, 100, 0, 0, 0);
    cyc(40, 42, 0, 0, 1);
    check("star_at_40_42", 32'(pix.background_RGB), 32'h49);
    cyc(40, 42, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 0, 0);
    cyc(40, 44, 0, 0, 1);
    check("star_scrolled", 32'(pix.background_RGB), 32'h49);
    cyc(40, 42, 0, 0, 1);
    repeat (956) cyc(0, 0, 1, 0, 0);
    cyc(40, 42, 0, 0, 1);
    check("scroll_wrap", 32'(pix.background_RGB), 32'h49);
    cyc(20, 100, 0, 1, 0);
    check("flash_on", 32'(pix.background_RGB), 32'h80);
    for (int f = 0; f < 60; f++) begin
      cyc(20, 100, f % 8 == 0, 0, 0);
      cyc(20, 100, 1, f == 20, 0);
      cyc(20, 100, 0, 0, 0);
    end
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) star_xy($urandom_range(0, 19), $urandom_range(0, 14), x, y);
      else begin
        x = $urandom_range(0, 1) ? xs[$urandom_range(0, 7)] : $urandom_range(0, 700);
        y = $urandom_range(0, 1) ? ys[$urandom_range(0, 8)] : $urandom_range(0, 520);
      end
      cyc(x, y, $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
    end
    cyc(20, 100, 0, 1, 0);
    repeat (10) cyc(20, 100, 1, 0, 0);
    resetN = 1'b0;
    #1;
    check("async_flashing", 32'(flashing), 32'h0);
    check("async_rgb", 32'(pix.background_RGB), 32'h00);
    check("async_dr", 32'(pix.bordersDR), 32'h0);
    m_fl = 0;
    m_fr = 0;
    m_sof = 0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    cyc(40, 42, 0, 0, 1);
    check("scroll_after_reset", 32'(pix.background_RGB), 32'h49);
    cyc(20, 100, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/background_scroller.md
Name: background_scroller

Overview:
- Parametrised successor to the static playfield background renderer.
- Draws the side, top and bottom movement borders and the player-zone line at parameter-set coordinates.
- Adds a vertically scrolling star field inside the playfield and a frame-timed flashing of the borders, triggered by game logic (e.g. player hit).
- Sits in the VGA pixel pipeline as the lowest-priority layer; its bordersDR output feeds collision logic.

Parameters:
- RGB_WIDTH, 8, colour width.
- PIXEL_WIDTH, 11, pixel coordinate width.
- X_FRAME, 639, last visible X.
- Y_FRAME, 479, last visible Y.
- SIDE_OFFSET, 20, left border at X=SIDE_OFFSET; right border at X=X_FRAME-SIDE_OFFSET.
- TOP_Y, 20, top border Y.
- BOTTOM_OFFSET, 20, bottom border at Y=Y_FRAME-BOTTOM_OFFSET.
- PLAYER_ZONE_Y, 310, player-zone line Y.
- STAR_CELL_LOG2, 5, star grid cell size is 2^STAR_CELL_LOG2 pixels square.
- SCROLL_DIV, 2, frames per 1-pixel scroll step (≥1).
- FLASH_FRAMES, 32, flash duration in frames.
- FLASH_HALF, 4, frames per flash on/off phase.
- BORDER_COLOR 8'h80, PLAYER_ZONE_COLOR 8'h10, FLASH_COLOR 8'hFF, STAR_COLOR 8'h49, BACKGROUND_COLOR 8'h00.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous active-low reset.
- pixelX  in  PIXEL_WIDTH  current pixel X.
- pixelY  in  PIXEL_WIDTH  current pixel Y.
- startOfFrame  in  1  one-cycle pulse, once per frame.
- stars_en  in  1  level; 1 = draw stars.
- flash_req  in  1  one-cycle pulse; starts or restarts the border flash.
- background_RGB  out  RGB_WIDTH  registered pixel colour.
- bordersDR  out  2  registered: 2'b00 none, 2'b01 movement border, 2'b10 player-zone line.
- flashing  out  1  registered: high while the flash is active.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, resetN).
- Reset values: background_RGB=BACKGROUND_COLOR, bordersDR=2'b00, flashing=0, scroll_offset=0, frame divider=0, flash FSM=IDLE.
- Latency: exactly 1 clock from pixelX/pixelY to background_RGB/bordersDR.
- Border hit: pixelX==SIDE_OFFSET, or pixelX==X_FRAME-SIDE_OFFSET, or pixelY==TOP_Y, or pixelY==Y_FRAME-BOTTOM_OFFSET.
- Player-zone line hit: pixelY==PLAYER_ZONE_Y.
- Playfield interior: SIDE_OFFSET<X<X_FRAME-SIDE_OFFSET and TOP_Y<Y<Y_FRAME-BOTTOM_OFFSET, excluding the player-zone line.
- Priority, highest first:
  - player-zone line: PLAYER_ZONE_COLOR, DR=10;
  - border: BORDER_COLOR (or FLASH_COLOR during the flash on-phase), DR=01;
  - star: STAR_COLOR, DR=00;
  - otherwise: BACKGROUND_COLOR, DR=00.
- Stars never assert bordersDR. Off-screen coordinates (X>X_FRAME or Y>Y_FRAME) give BACKGROUND_COLOR, DR=00.
- Scroll:
  - Divider counts startOfFrame pulses 0..SCROLL_DIV-1.
  - On wrap, scroll_offset increments.
  - scroll_offset wraps from Y_FRAME to 0.
- Star placement:
  - sy = pixelY - scroll_offset; if negative, add Y_FRAME+1.
  - cx = pixelX>>L, cy = sy>>L, where L = STAR_CELL_LOG2 and M = 2^L - 1.
  - Star pixel when (pixelX & M) == ((cx*5 + cy*3) & M) and (sy & M) == ((cx*3 + cy*7) & M), inside the interior, with stars_en=1.
  - Result: stars move down 1 pixel per step.
- Flash FSM (IDLE, FLASH):
  - IDLE: on flash_req go to FLASH; frame_cnt=0, phase_cnt=0, phase=on.
  - FLASH: each startOfFrame increments frame_cnt. Every FLASH_HALF frames, phase toggles.
  - FLASH: on the frame_cnt==FLASH_FRAMES-1 startOfFrame, go to IDLE.
  - flashing = (state==FLASH), registered.
  - flash_req during FLASH restarts the counters (retrigger); no queueing.
  - flash_req and startOfFrame in the same cycle: the request wins; counting starts at the next startOfFrame.
- Reset asserted mid-frame or mid-flash: all state clears immediately; output is BACKGROUND_COLOR on the next active clock after release.

Decomposition:
- Package background_pkg:
  - default colour constants;
  - bordersDR encodings DR_NONE / DR_BORDER / DR_PLAYER_ZONE;
  - flash state enum.
- Sub-module star_field:
  - holds the frame divider and scroll_offset;
  - takes clk, resetN, startOfFrame, pixelX, pixelY;
  - outputs a combinational star_hit.
- Border logic, flash FSM and the output register stay in background_scroller.

Test Plan:
- Reset released; pixel (20,100) -> next clk RGB=8'h80, DR=01. Pixel (100,310) -> RGB=8'h10, DR=10. Pixel (100,20) -> DR=01.
- Pixel (20,310) -> RGB=8'h10, DR=10 (player line beats border). Pixel (700,100) -> RGB=8'h00, DR=00.
- stars_en=1, scroll=0, pixel (32,32) (cx=cy=1, star at (8,10) in cell) -> pixel (40,42) gives RGB=8'h49, DR=00. stars_en=0 -> 8'h00.
- SCROLL_DIV=2: 4 startOfFrame pulses -> scroll_offset=2; star moves from (40,42) to (40,44). 960 pulses -> scroll_offset wraps to 0.
- flash_req pulse, pixel (20,100) -> flashing=1; RGB=8'hFF for 4 frames, then 8'h80 for 4 frames, alternating; flashing=0 after 32 frames. Retrigger at frame 20 -> flashing stays high until 32 frames after the retrigger.
- resetN low during FLASH at frame 10 -> flashing=0, RGB=8'h00, DR=00 immediately; scroll_offset=0.
